// File: rtl/fifo_rd_scheduler_pkg.sv
// ============================================================================
// Module      : fifo_rd_sched_pkg
// Description : Shared types and helpers for the FIFO read-port scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_sched_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width that stays usable (>= 1 bit) even for two consumers.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_scheduler_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority pick starting after i_rr_last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import fifo_rd_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [clog2_min1(NUM_REQ)-1:0] i_rr_last,
  output logic                           o_any,
  output logic [clog2_min1(NUM_REQ)-1:0] o_winner
);

  localparam int c_ID_W = clog2_min1(NUM_REQ);

  logic [c_ID_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    w_idx    = '0;
    o_winner = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_idx = c_ID_W'((int'(i_rr_last) + off) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_scheduler.sv
// ============================================================================
// Module      : fifo_rd_scheduler
// Description : Round-robin, burst-bounded sharing of the async FIFO read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_scheduler
  import fifo_rd_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                           rclk,
  input  logic                           rrst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic                           empty,
  input  logic [DATA_WIDTH-1:0]          fifo_rdata,
  output logic                           r_en,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [clog2_min1(NUM_REQ)-1:0] rd_id,
  output logic                           busy
);

  localparam int                 c_ID_W  = clog2_min1(NUM_REQ);
  localparam int                 c_CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(MAX_BURST - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [c_ID_W-1:0]       r_owner;
  logic [c_ID_W-1:0]       r_rr_last;
  logic [c_ID_W-1:0]       w_winner;
  logic [c_CNT_W-1:0]      r_burst_cnt;
  logic                    w_any;
  logic                    w_pop;
  logic                    w_exit;
  logic                    r_rd_valid;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [c_ID_W-1:0]       r_rd_id;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req     (req),
    .i_rr_last (r_rr_last),
    .o_any     (w_any),
    .o_winner  (w_winner)
  );

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pop is blocked by reset so a word is never consumed without being returned.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        w_pop  = req[r_owner] & ~empty & ~rrst;
        w_exit = ~req[r_owner] | (w_pop & (r_burst_cnt == c_LAST));
        if (w_exit) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_gnt       <= '0;
      r_owner     <= '0;
      r_rr_last   <= c_ID_W'(NUM_REQ - 1);
      r_burst_cnt <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_id     <= '0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= fifo_rdata;
        r_rd_id   <= r_owner;
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt       <= NUM_REQ'(1) << w_winner;
            r_owner     <= w_winner;
            r_rr_last   <= w_winner;
            r_burst_cnt <= '0;
          end
        end
        BURST: begin
          if (w_exit) begin
            r_gnt <= '0;
          end else if (w_pop) begin
            r_burst_cnt <= r_burst_cnt + c_CNT_W'(1);
          end
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  assign r_en     = w_pop;
  assign gnt      = r_gnt;
  assign busy     = (r_state == BURST);
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_id    = r_rd_id;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_scheduler.sv
// ============================================================================
// Module      : tb_fifo_rd_scheduler
// Description : Directed bench for fifo_rd_scheduler (MAX_BURST=4 and =1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_scheduler;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       empty;
  logic [3:0] req;
  logic [3:0] req1;
  logic [7:0] ptr;
  logic [7:0] fifo_rdata;
  logic [7:0] fifo_rdata1;

  logic       r_en, rd_valid, busy;
  logic [3:0] gnt;
  logic [7:0] rd_data;
  logic [1:0] rd_id;
  logic       r_en1, rd_valid1, busy1;
  logic [3:0] gnt1;
  logic [7:0] rd_data1;
  logic [1:0] rd_id1;

  int total = 0;
  int bad   = 0;
  int exp_word;

  always #5 rclk = ~rclk;

  // FIFO model: word at the read pointer is 0x10 + pointer.
  always @(posedge rclk) begin
    if (rrst)      ptr <= 8'h00;
    else if (r_en) ptr <= ptr + 8'h01;
  end
  assign fifo_rdata  = 8'h10 + ptr;
  assign fifo_rdata1 = 8'hA5;

  fifo_rd_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .rclk(rclk), .rrst(rrst), .req(req), .empty(empty), .fifo_rdata(fifo_rdata),
    .r_en(r_en), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_id(rd_id), .busy(busy)
  );

  fifo_rd_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
    .rclk(rclk), .rrst(rrst), .req(req1), .empty(empty), .fifo_rdata(fifo_rdata1),
    .r_en(r_en1), .gnt(gnt1), .rd_valid(rd_valid1), .rd_data(rd_data1),
    .rd_id(rd_id1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge rclk);
    #2;
  endtask

  // Starts at the grant cycle; ends at the cycle after the trailing IDLE gap.
  task automatic burst(input int owner, input int n);
    for (int k = 0; k < n; k++) begin
      chk("b_gnt", gnt, 32'(4'b0001 << owner));
      chk("b_ren", r_en, 1);
      chk("b_busy", busy, 1);
      if (k == 0) begin
        chk("b_rv0", rd_valid, 0);
      end else begin
        chk("b_rv", rd_valid, 1);
        chk("b_rid", rd_id, owner);
        chk("b_rdata", rd_data, exp_word - 1);
      end
      exp_word++;
      tick;
    end
    chk("e_gnt", gnt, 0);
    chk("e_ren", r_en, 0);
    chk("e_busy", busy, 0);
    chk("e_rv", rd_valid, 1);
    chk("e_rid", rd_id, owner);
    chk("e_rdata", rd_data, exp_word - 1);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst = 1'b1; req = 4'b0; req1 = 4'b0; empty = 1'b0;
    tick; tick;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rid", rd_id, 0);
    chk("rst_ren", r_en, 0);

    // Single consumer: burst of 4, one idle cycle, re-grant
    rrst = 1'b0; req = 4'b0001; exp_word = 8'h10; #1;
    chk("t1_idle_gnt", gnt, 0);
    tick;
    burst(0, 4);
    chk("t1_regrant", gnt, 4'b0001);
    req = 4'b0; #1;
    chk("t1_drop_ren", r_en, 0);
    tick;
    chk("t1_exit_gnt", gnt, 0);

    // All requesting: rotation 0,1,2,3,0
    rrst = 1'b1; tick;
    rrst = 1'b0; req = 4'b1111; exp_word = 8'h10; #1;
    tick;
    burst(0, 4); burst(1, 4); burst(2, 4); burst(3, 4); burst(0, 4);
    chk("t2_next_gnt", gnt, 4'b0010);
    req = 4'b0; #1;
    tick;
    chk("t2_idle_gnt", gnt, 0);

    // Owner 2, empty stall after 2 pops
    req = 4'b0100; #1;
    tick;
    chk("t3_gnt", gnt, 4'b0100);
    chk("t3_ren0", r_en, 1);
    tick;
    chk("t3_ren1", r_en, 1);
    chk("t3_rdata0", rd_data, exp_word);
    tick;
    empty = 1'b1; #1;
    chk("t3_s0_ren", r_en, 0);
    chk("t3_s0_rv", rd_valid, 1);
    chk("t3_s0_rdata", rd_data, exp_word + 1);
    for (int s = 1; s < 3; s++) begin
      tick;
      chk("t3_s_ren", r_en, 0);
      chk("t3_s_rv", rd_valid, 0);
      chk("t3_s_gnt", gnt, 4'b0100);
      chk("t3_s_busy", busy, 1);
    end
    tick;
    empty = 1'b0; #1;
    chk("t3_r_ren", r_en, 1);
    chk("t3_r_rv", rd_valid, 0);
    tick;
    chk("t3_r2_ren", r_en, 1);
    chk("t3_r2_rdata", rd_data, exp_word + 2);
    tick;
    chk("t3_end_gnt", gnt, 0);
    chk("t3_end_ren", r_en, 0);
    chk("t3_end_rdata", rd_data, exp_word + 3);
    chk("t3_end_rid", rd_id, 2);
    exp_word += 4;
    req = 4'b0; #1;
    tick;
    chk("t3_after_rv", rd_valid, 0);
    chk("t3_after_gnt", gnt, 0);

    // Owner 1 drops after one pop; next grant goes to 2
    req = 4'b0110; #1;
    tick;
    chk("t4_gnt", gnt, 4'b0010);
    chk("t4_ren", r_en, 1);
    tick;
    req = 4'b0100; #1;
    chk("t4_drop_ren", r_en, 0);
    chk("t4_rv", rd_valid, 1);
    chk("t4_rid", rd_id, 1);
    chk("t4_rdata", rd_data, exp_word);
    tick;
    chk("t4_exit_gnt", gnt, 0);
    chk("t4_exit_rv", rd_valid, 0);
    tick;
    chk("t4_next_gnt", gnt, 4'b0100);
    req = 4'b0; #1;
    tick;

    // Reset in the middle of a burst
    req = 4'b0001; #1;
    tick;
    chk("t5_gnt", gnt, 4'b0001);
    chk("t5_ren", r_en, 1);
    rrst = 1'b1; #1;
    chk("t5_rst_ren", r_en, 0);
    tick;
    chk("t5_gnt0", gnt, 0);
    chk("t5_rv0", rd_valid, 0);
    chk("t5_busy0", busy, 0);
    chk("t5_rdata0", rd_data, 0);
    rrst = 1'b0; req = 4'b1111; #1;
    tick;
    chk("t5_first_gnt", gnt, 4'b0001);
    req = 4'b0; #1;
    tick;

    // MAX_BURST=1: alternating single-word bursts 0,2,0,2
    req1 = 4'b0101; #1;
    chk("t6_gnt0", gnt1, 0);
    for (int t = 1; t <= 8; t++) begin
      tick;
      if (t % 2 == 1) begin
        chk("t6_gnt", gnt1, (t % 4 == 1) ? 4'b0001 : 4'b0100);
        chk("t6_ren", r_en1, 1);
        chk("t6_rv_lo", rd_valid1, 0);
      end else begin
        chk("t6_gap", gnt1, 0);
        chk("t6_ren_lo", r_en1, 0);
        chk("t6_rv", rd_valid1, 1);
        chk("t6_rid", rd_id1, (t % 4 == 2) ? 0 : 2);
        chk("t6_rdata", rd_data1, 8'hA5);
      end
    end
    req1 = 4'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_rd_scheduler.md
Name: fifo_rd_scheduler

Overview:
- Shares the single read port of the async FIFO's read domain among NUM_REQ consumers.
- Round-robin arbitration with bounded bursts; drives r_en into the read-pointer logic, gated by empty.
- Captures the FIFO read word and returns it tagged with the consumer ID.
- Lives entirely in the rclk domain, beside the read-pointer handler.

Parameters:
NUM_REQ, 4, number of consumers (2..16)
DATA_WIDTH, 8, FIFO word width
MAX_BURST, 4, max words read per grant (1..255)

Ports:
rclk  input  1  read-domain clock
rrst  input  1  synchronous active-high reset
req  input  NUM_REQ  per-consumer read request, level, held while words wanted
empty  input  1  FIFO empty flag from read-pointer handler (registered in rclk)
fifo_rdata  input  DATA_WIDTH  FIFO read word at current read pointer, valid combinationally while !empty
r_en  output  1  FIFO read enable (one word popped per rclk cycle it is high)
gnt  output  NUM_REQ  one-hot current owner, registered
rd_valid  output  1  rd_data/rd_id valid this cycle
rd_data  output  DATA_WIDTH  captured word
rd_id  output  $clog2(NUM_REQ)  consumer index owning rd_data
busy  output  1  high while in BURST

Behaviour:
- Interface: one clock rclk; reset rrst is synchronous and active-high. All state updates on posedge rclk; rrst sampled only on posedge.
- Reset values:
  - state=IDLE, gnt=0, busy=0, rd_valid=0, rd_data=0, rd_id=0, burst_cnt=0.
  - rr_last=NUM_REQ-1, so consumer 0 wins first.
  - r_en forced 0 in any cycle rrst is high.
- FSM has two states.
  - IDLE: if |req, winner = first set req index searching cyclically from rr_last+1. Next cycle: gnt=onehot(winner), owner=winner, rr_last=winner, burst_cnt=0, state=BURST. If no req, stay IDLE.
  - BURST: r_en = req[owner] & !empty & !rrst (combinational from registered state and inputs). Each cycle r_en=1, burst_cnt increments.
- BURST exit to IDLE (gnt=0 next cycle) when either:
  - r_en=1 and burst_cnt==MAX_BURST-1 (final word), or
  - req[owner]=0.
- empty=1 with req[owner]=1: stall in BURST, no pop, no timeout, burst_cnt unchanged.
- Arbitration gap: one IDLE cycle between bursts; minimum re-grant latency is 1 cycle from req to gnt.
- Data return:
  - On any cycle with r_en=1: rd_data<=fifo_rdata, rd_id<=owner, rd_valid<=1.
  - Otherwise rd_valid<=0; rd_data and rd_id hold.
  - Latency is 1 cycle from r_en to rd_valid. No backpressure: consumers must accept rd_valid.
- Simultaneous events:
  - req[owner] drop in the same cycle as the final word: single exit to IDLE.
  - Non-owner req changes during BURST are ignored until IDLE.
- Reset mid-burst: r_en=0 in the reset cycle, so no word is lost in the FIFO. All regs return to reset values next cycle; no rd_valid for a pop that did not occur.
- burst_cnt width is $clog2(MAX_BURST+1) and never wraps.
- rr_last rotation wraps NUM_REQ-1 -> 0.

Decomposition:
- Package fifo_rd_sched_pkg holds:
  - state enum {IDLE, BURST}
  - localparam ID_W = $clog2(NUM_REQ) helper (function clog2_min1 returning ≥1)
- Sub-module rr_arbiter: combinational rotating-priority pick (inputs req and rr_last; outputs any and winner index). Instanced once.

Test Plan:
- Reset then req=4'b0001, empty=0, fifo_rdata incrementing 0x10.. -> gnt=0001 one cycle after req; r_en high 4 cycles; rd_valid 4 cycles carrying 0x10..0x13 with rd_id=0, each one cycle after its r_en; then gnt=0, and gnt=0001 again after one IDLE cycle.
- req=4'b1111 held, empty=0 -> grant order 0,1,2,3,0 with exactly 4 pops each; rd_id sequence matches; one idle cycle between bursts.
- Owner 2 granted, empty=1 for 3 cycles mid-burst after 2 pops -> r_en=0 and no rd_valid during the stall; resumes and completes exactly 2 more pops.
- req[1] dropped after 1 pop -> burst ends with 1 rd_valid; next grant goes to req[2] if set, not back to 1.
- rrst asserted while r_en high in BURST -> r_en=0 that cycle; next cycle gnt=0, rd_valid=0, busy=0; first grant after release goes to consumer 0.
- MAX_BURST=1, req=4'b0101 -> alternating bursts 0,2,0,2 with one word each and gnt toggling every 2 cycles.
